// File: rtl/apb_bridge_nslv.sv
// APB3 master bridge: one host request at a time, fanned out to NUM_SLV slaves
// by an address field, with wait states, decode-error and timeout reporting.
module apb_bridge_nslv #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 2,
    parameter int SEL_LSB = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                      pclk,
    input  logic                      prst_n,
    input  logic                      host_valid,
    output logic                      host_ready,
    input  logic                      host_write,
    input  logic [ADDR_W-1:0]         host_addr,
    input  logic [DATA_W-1:0]         host_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic                host_ready_q, host_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [SEL_W-1:0]    idx;
    logic                hit;
    logic [NUM_SLV-1:0]  onehot;
    logic                sel_rdy;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;

    // psel_q is one-hot while a slave is addressed, so it doubles as the mux select
    always_comb begin
        idx       = host_addr[SEL_LSB +: SEL_W];
        hit       = 32'(idx) < 32'(NUM_SLV);
        onehot    = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            onehot[i] = (32'(idx) == 32'(i));
            if (psel_q[i]) begin
                sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
            end
        end
        sel_rdy = |(pready & psel_q);
        sel_err = |(pslverr & psel_q);
    end

    always_comb begin
        state_d       = state_q;
        host_ready_d  = host_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host_valid && host_ready_q) begin
                    host_ready_d = 1'b0;
                    pwrite_d     = host_write;
                    paddr_d      = host_addr;
                    pwdata_d     = host_wdata;
                    if (hit) begin
                        state_d = SETUP;
                        psel_d  = onehot;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (sel_rdy) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    if (!pwrite_q && !sel_err) begin
                        rsp_rdata_d = sel_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    cnt_d         = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d      = IDLE;
                host_ready_d = 1'b1;
            end
            default: begin
                state_d      = IDLE;
                host_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q       <= IDLE;
            host_ready_q  <= 1'b1;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_ready_q  <= host_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign host_ready  = host_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
